// File: rtl/sum_accum.sv
// ============================================================================
// Module   : sum_accum
// Summary  : Accumulates COUNT unsigned samples into a wider total and hands
//            each total to a valid/ready consumer, with a sticky carry flag.
// Revision : 1.0
// ============================================================================
`default_nettype none

module sum_accum #(
  parameter int WIDTH     = 8,
  parameter int COUNT     = 4,
  parameter int ACC_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 clear,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     in_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [ACC_WIDTH-1:0] out_data,
  output logic                 out_ovf,
  output logic                 busy
);

  localparam int CNT_W = (COUNT > 1) ? $clog2(COUNT) : 1;
  localparam logic [CNT_W-1:0] C_LAST = CNT_W'(COUNT - 1);

  typedef enum logic [0:0] {
    ST_ACCUM = 1'b0,
    ST_HOLD  = 1'b1
  } state_t;

  state_t               state_q;
  logic [ACC_WIDTH-1:0] acc_q;
  logic [CNT_W-1:0]     cnt_q;
  logic                 ovf_q;
  logic                 out_valid_q;
  logic [ACC_WIDTH-1:0] out_data_q;
  logic                 out_ovf_q;

  logic [ACC_WIDTH:0]   sum_d;
  logic                 ovf_d;
  logic                 accept;
  logic                 last_sample;

  // One extra bit on the adder captures the carry out of ACC_WIDTH.
  assign sum_d       = {1'b0, acc_q} + {1'b0, ACC_WIDTH'(in_data)};
  assign ovf_d       = ovf_q | sum_d[ACC_WIDTH];
  assign accept      = in_valid && (state_q == ST_ACCUM);
  assign last_sample = (cnt_q == C_LAST);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_ACCUM;
      acc_q       <= '0;
      cnt_q       <= '0;
      ovf_q       <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_ovf_q   <= 1'b0;
    end else if (clear) begin
      // Abort wins over everything; the last result value stays visible.
      state_q     <= ST_ACCUM;
      acc_q       <= '0;
      cnt_q       <= '0;
      ovf_q       <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      case (state_q)
        ST_ACCUM: begin
          if (accept) begin
            acc_q <= sum_d[ACC_WIDTH-1:0];
            cnt_q <= cnt_q + CNT_W'(1);
            ovf_q <= ovf_d;
            if (last_sample) begin
              out_data_q  <= sum_d[ACC_WIDTH-1:0];
              out_ovf_q   <= ovf_d;
              out_valid_q <= 1'b1;
              state_q     <= ST_HOLD;
            end
          end
        end
        ST_HOLD: begin
          if (out_valid_q && out_ready) begin
            acc_q       <= '0;
            cnt_q       <= '0;
            ovf_q       <= 1'b0;
            out_valid_q <= 1'b0;
            state_q     <= ST_ACCUM;
          end
        end
        default: begin
          state_q <= ST_ACCUM;
        end
      endcase
    end
  end

  assign in_ready  = (state_q == ST_ACCUM);
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_ovf   = out_ovf_q;
  assign busy      = (state_q == ST_HOLD) || (cnt_q != '0);

endmodule

`default_nettype wire

// File: doc/sum_accum.md
# sum_accum

Downstream stage of the 8-bit `adder`: it consumes the adder's `sum` one sample at a time and accumulates `COUNT` accepted samples into a wider total. Each completed total is presented with a valid/ready handshake to the next consumer. Input uses a valid/ready handshake so an upstream operand sequencer can stall. The block sits between the adder and any result sink (display/check logic).

## Interface
- `WIDTH`, 8, width of input samples (matches adder `sum`)
- `COUNT`, 4, samples per result; legal range 2..255
- `ACC_WIDTH`, 16, accumulator/result width; must be ≥ `WIDTH`

- `clk`  in  1  rising-edge clock
- `reset`  in  1  asynchronous, active-low reset
- `clear`  in  1  synchronous abort; discards partial batch and any pending result
- `in_valid`  in  1  `in_data` is valid
- `in_ready`  out  1  block accepts a sample this cycle
- `in_data`  in  `WIDTH`  sample from adder `sum`, unsigned
- `out_valid`  out  1  `out_data`/`out_ovf` hold a completed result
- `out_ready`  in  1  consumer takes result this cycle
- `out_data`  out  `ACC_WIDTH`  sum of `COUNT` samples modulo 2^`ACC_WIDTH`
- `out_ovf`  out  1  carry out of `ACC_WIDTH` occurred at least once during the batch
- `busy`  out  1  at least one sample accepted in the current batch, or result pending

## Operation
- Two states: ACCUM, HOLD. Reset state ACCUM.
- `in_ready` = (state == ACCUM), decoded from the state register only; no combinational path from any input.
- Sample accept = `in_valid && in_ready`.
- ACCUM, on accept: `acc <= acc + zero_ext(in_data)`, `cnt <= cnt + 1`, and `ovf <= ovf | carry`, where `carry` is the carry out of `ACC_WIDTH`.
- ACCUM, when the accept has `cnt == COUNT-1`: load the final sum into `out_data` and the final ovf into `out_ovf`, set `out_valid <= 1`, and go to HOLD.
- ACCUM, when `in_valid` is low: hold all state. Gaps between samples are allowed.
- HOLD: `in_ready = 0`. `out_data`, `out_ovf` and `out_valid` are held stable until `out_valid && out_ready`.
- HOLD, on the output handshake: clear `acc`, `cnt` and `ovf`; drop `out_valid`; return to ACCUM.
- Arithmetic is unsigned; `acc` wraps modulo 2^`ACC_WIDTH`; `out_ovf` is sticky within a batch only.
- `clear` has highest priority in every state. On `clear`, the next state is:
  - `acc = 0`, `cnt = 0`, `ovf = 0`;
  - `out_valid = 0`;
  - state ACCUM.
  - A sample presented in the same cycle as `clear` is discarded, even though `in_ready` was 1.
- `busy` = (state == HOLD) || (`cnt` != 0).

## Timing
- Reset (asynchronous assert; release synchronous to `clk`) forces:
  - state ACCUM, `acc = 0`, `cnt = 0`;
  - `out_valid = 0`, `out_data = 0`, `out_ovf = 0`, `busy = 0`;
  - `in_ready = 1`.
- Reset mid-batch or mid-HOLD drops everything immediately, with no result emitted.
- Result latency: `out_valid` is high in the cycle after the `COUNT`-th accept.
- Output handshake completes on a rising edge with `out_valid && out_ready`. `in_ready` is high in the following cycle.
- Peak throughput: one result per `COUNT`+1 cycles, because there is one HOLD cycle minimum.
- `out_ready` high while `out_valid` is low has no effect.
- `out_data` is registered and changes only when loaded (at the end of a batch), on clear (value held), or on reset (0).
- While `out_valid` is high, `out_data` and `out_ovf` must not change.

## Test plan
- Reset, then 4 consecutive samples of 122 (2+120 from the adder) with `out_ready` = 1:
  - `out_valid` high exactly 1 cycle after the 4th accept;
  - `out_data` = 488, `out_ovf` = 0;
  - `in_ready` low 1 cycle, then high.
- `ACC_WIDTH` = 9, `COUNT` = 4, samples 255 ×4:
  - `out_data` = 508 (1020 mod 512), `out_ovf` = 1;
  - the next batch of 1,1,1,1 gives 4 with `out_ovf` = 0.
- Backpressure: complete a batch with `out_ready` = 0 for 5 cycles while `in_valid` = 1 and `in_data` varies:
  - `out_valid`, `out_data` and `out_ovf` are stable;
  - `in_ready` = 0, no sample accepted;
  - raising `out_ready` completes the handshake in 1 cycle.
- `in_valid` gaps: samples 10, 20, 30, 40 with 2 idle cycles between each → `out_data` = 100, `busy` = 1 from the first accept until the handshake.
- `clear` after 2 samples (5, 7), asserted together with a third sample 9:
  - the sample is discarded and `busy` = 0;
  - the next samples 1,2,3,4 give `out_data` = 10.
- Assert `reset` low asynchronously during HOLD and mid-batch:
  - outputs go to reset values without waiting for a clock edge;
  - after release, a fresh 4-sample batch of 3 gives 12.
